// File: rtl/cnn_layer_accel_macc_chain.sv
// Multi-lane MAC / squared-difference engine: input delay, products, registered adder tree, windowed accumulator.
// Latency C_INPUT_DELAY+clog2(C_NUM_LANES)+2 edges from a window's last beat; CNN_LAYER_ACCEL_MACC_CHAIN_SAT_EN clamps the result.
// Backpressure: a held, unaccepted result freezes every stage and drops in_ready until out_ready.
module cnn_layer_accel_macc_chain #(
   parameter int C_NUM_LANES       = 4,
   parameter int C_DSP_INPUT_WIDTH = 16,
   parameter int C_INPUT_DELAY     = 1,
   parameter int C_ACCUM_WIDTH     = 48,
   parameter int C_OUTPUT_WIDTH    = 16,
   parameter int C_CNT_WIDTH       = 16
) (
   input  logic                                     clk,
   input  logic                                     rst,
   input  logic                                     cfg_mode,
   input  logic [C_CNT_WIDTH-1:0]                   cfg_num_accum,
   input  logic [5:0]                               cfg_shift,
   input  logic                                     in_valid,
   output logic                                     in_ready,
   input  logic [C_NUM_LANES*C_DSP_INPUT_WIDTH-1:0] in_a,
   input  logic [C_NUM_LANES*C_DSP_INPUT_WIDTH-1:0] in_b,
   output logic                                     out_valid,
   input  logic                                     out_ready,
   output logic [C_OUTPUT_WIDTH-1:0]                out_data,
   output logic [C_ACCUM_WIDTH-1:0]                 out_accum,
   output logic                                     out_sat,
   output logic                                     busy
);
   localparam int N  = C_NUM_LANES;
   localparam int W  = C_DSP_INPUT_WIDTH;
   localparam int D  = C_INPUT_DELAY;
   localparam int A  = C_ACCUM_WIDTH;
   localparam int O  = C_OUTPUT_WIDTH;
   localparam int PW = 2*W + 2;
   localparam int T  = (N > 1) ? $clog2(N) : 0;
   localparam int NP = 1 << T;
   localparam int NV = D + 1 + T;

   logic                   ce;
   logic [NV-1:0]          vld;
   logic [N*W-1:0]         a_d [0:D-1];
   logic [N*W-1:0]         b_d [0:D-1];
   // Heap-ordered tree: leaves at NP..2NP-1, node k sums 2k and 2k+1, root at 1.
   logic signed [A-1:0]    node [1:2*NP-1];
   logic [C_CNT_WIDTH-1:0] cnt;
   logic [C_CNT_WIDTH-1:0] last_idx;
   logic signed [A-1:0]    acc;
   logic signed [A-1:0]    acc_next;
   logic                   load;
   logic [O-1:0]           res;

   function automatic logic signed [A-1:0] lane_prod(input logic signed [W-1:0] a,
                                                     input logic signed [W-1:0] b,
                                                     input logic            mode);
      logic signed [W:0]    d;
      logic signed [PW-1:0] p;
      d = {a[W-1], a} - {b[W-1], b};
      if (mode)
         p = PW'(d) * PW'(d);
      else
         p = PW'(a) * PW'(b);
      return A'(p);
   endfunction

   assign ce       = !(out_valid && !out_ready);
   assign in_ready = ce;

   always_ff @(posedge clk) begin
      if (rst)
         vld <= '0;
      else if (ce)
         vld <= {vld[NV-2:0], in_valid};
   end

   always_ff @(posedge clk) begin
      if (ce) begin
         a_d[0] <= in_a;
         b_d[0] <= in_b;
         for (int k = 1; k < D; k++) begin
            a_d[k] <= a_d[k-1];
            b_d[k] <= b_d[k-1];
         end
         for (int i = 0; i < N; i++)
            node[NP+i] <= lane_prod($signed(a_d[D-1][i*W +: W]), $signed(b_d[D-1][i*W +: W]), cfg_mode);
         for (int i = N; i < NP; i++)
            node[NP+i] <= '0;
         for (int k = 1; k < NP; k++)
            node[k] <= node[2*k] + node[2*k+1];
      end
   end

   assign last_idx = (cfg_num_accum == '0) ? '0 : cfg_num_accum - C_CNT_WIDTH'(1);
   assign acc_next = (cnt == '0) ? node[1] : acc + node[1];
   assign load     = vld[NV-1] && (cnt == last_idx);

`ifdef CNN_LAYER_ACCEL_MACC_CHAIN_SAT_EN
   logic signed [A-1:0] acc_shift;
   logic                ovf;
   logic                sat_q;

   assign acc_shift = acc_next >>> cfg_shift;
   // In range iff every bit from the result sign bit upward matches the sign.
   assign ovf = acc_shift[A-1:O-1] != {(A-O+1){acc_shift[A-1]}};
   assign res = !ovf ? acc_shift[O-1:0]
              : (acc_shift[A-1] ? {1'b1, {(O-1){1'b0}}} : {1'b0, {(O-1){1'b1}}});

   always_ff @(posedge clk) begin
      if (rst)
         sat_q <= 1'b0;
      else if (ce && load)
         sat_q <= ovf;
   end
   assign out_sat = sat_q;
`else
   assign res     = O'(acc_next >>> cfg_shift);
   assign out_sat = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt       <= '0;
         acc       <= '0;
         out_valid <= 1'b0;
         out_data  <= '0;
         out_accum <= '0;
      end else if (ce) begin
         if (vld[NV-1]) begin
            acc <= acc_next;
            cnt <= load ? '0 : cnt + C_CNT_WIDTH'(1);
         end
         if (load) begin
            out_accum <= acc_next;
            out_data  <= res;
            out_valid <= 1'b1;
         end else if (out_ready) begin
            out_valid <= 1'b0;
         end
      end
   end

   assign busy = (|vld) || (cnt != '0) || out_valid;

endmodule

// File: tb/tb_cnn_layer_accel_macc_chain.sv
// Bench for cnn_layer_accel_macc_chain: directed literal cases plus randomized windows against a reference model.
module tb_cnn_layer_accel_macc_chain;
   localparam int N = 4;
   localparam int W = 16;
   localparam int A = 48;
   localparam int O = 16;
   localparam int CW = 16;

   logic            clk;
   logic            rst;
   logic            cfg_mode;
   logic [CW-1:0]   cfg_num_accum;
   logic [5:0]      cfg_shift;
   logic            in_valid;
   logic            in_ready;
   logic [N*W-1:0]  in_a;
   logic [N*W-1:0]  in_b;
   logic            out_valid;
   logic            out_ready;
   logic [O-1:0]    out_data;
   logic [A-1:0]    out_accum;
   logic            out_sat;
   logic            busy;

   cnn_layer_accel_macc_chain dut (
      .clk(clk), .rst(rst), .cfg_mode(cfg_mode), .cfg_num_accum(cfg_num_accum),
      .cfg_shift(cfg_shift), .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a),
      .in_b(in_b), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_accum(out_accum), .out_sat(out_sat), .busy(busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [O-1:0] data;
      logic [A-1:0] accum;
      logic         sat;
   } res_t;

   res_t    exp_q[$];
   res_t    out_log[$];
   res_t    cur;
   longint  m_acc;
   int      m_cnt;
   int      pass_cnt = 0;
   int      total_cnt = 0;
   int      ready_mode = 1;

   task automatic chk(input string name, input longint act, input longint exp);
      total_cnt++;
      if (act == exp)
         pass_cnt++;
      else
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
   endtask

   function automatic logic [N*W-1:0] pack4(input int x0, input int x1, input int x2, input int x3);
      logic [N*W-1:0] v;
      v = {16'(x3), 16'(x2), 16'(x1), 16'(x0)};
      return v;
   endfunction

   // Reference: sum over lanes of a*b or (a-b)^2 using plain integer arithmetic.
   function automatic longint beat_sum(input logic [N*W-1:0] a, input logic [N*W-1:0] b, input logic mode);
      longint s = 0;
      for (int i = 0; i < N; i++) begin
         longint x = longint'($signed(a[i*W +: W]));
         longint y = longint'($signed(b[i*W +: W]));
         s += mode ? (x - y) * (x - y) : x * y;
      end
      return s;
   endfunction

   function automatic res_t expect_of(input longint total, input int shift);
      res_t   r;
      longint sx;
      r.accum = total[A-1:0];
      sx = total;
      sx = (sx <<< (64 - A)) >>> (64 - A);
      sx = sx >>> shift;
`ifdef CNN_LAYER_ACCEL_MACC_CHAIN_SAT_EN
      if (sx > 32767) begin
         r.data = 16'h7fff; r.sat = 1'b1;
      end else if (sx < -32768) begin
         r.data = 16'h8000; r.sat = 1'b1;
      end else begin
         r.data = 16'(sx); r.sat = 1'b0;
      end
`else
      r.data = 16'(sx);
      r.sat  = 1'b0;
`endif
      return r;
   endfunction

   // Single compare process: model follows accepted beats, checks every accepted result.
   always @(negedge clk) begin
      if (rst) begin
         exp_q.delete();
         m_acc = 0;
         m_cnt = 0;
      end else begin
         if (out_valid && out_ready) begin
            cur.data = out_data; cur.accum = out_accum; cur.sat = out_sat;
            if (exp_q.size() == 0) begin
               chk("unexpected_result", 1, 0);
            end else begin
               res_t e;
               e = exp_q.pop_front();
               chk("result_data", longint'(out_data), longint'(e.data));
               chk("result_accum", longint'(out_accum), longint'(e.accum));
               chk("result_sat", longint'(out_sat), longint'(e.sat));
            end
            out_log.push_back(cur);
         end
         if (in_valid && in_ready) begin
            int     n;
            longint s;
            n = (cfg_num_accum == 0) ? 1 : int'(cfg_num_accum);
            s = beat_sum(in_a, in_b, cfg_mode);
            m_acc = (m_cnt == 0) ? s : m_acc + s;
            if (m_cnt == n - 1) begin
               exp_q.push_back(expect_of(m_acc, int'(cfg_shift)));
               m_cnt = 0;
            end else begin
               m_cnt++;
            end
         end
      end
   end

   initial begin
      out_ready = 1'b1;
      forever begin
         @(posedge clk);
         #2;
         case (ready_mode)
            0:       out_ready = 1'b0;
            1:       out_ready = 1'b1;
            default: out_ready = ($urandom_range(0, 3) != 0);
         endcase
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic send(input logic [N*W-1:0] a, input logic [N*W-1:0] b);
      int g = 0;
      in_a = a; in_b = b; in_valid = 1'b1;
      while (!in_ready && g < 200) begin
         step(1);
         g++;
      end
      if (g >= 200) chk("send_timeout", 1, 0);
      step(1);
      in_valid = 1'b0;
   endtask

   task automatic wait_idle();
      int g = 0;
      while (busy && g < 300) begin
         step(1);
         g++;
      end
      if (g >= 300) chk("idle_timeout", 1, 0);
   endtask

   task automatic wait_results(input int base, input int k);
      int g = 0;
      while (out_log.size() < base + k && g < 200) begin
         step(1);
         g++;
      end
      if (g >= 200) chk("result_timeout", out_log.size(), base + k);
   endtask

   task automatic set_cfg(input logic mode, input int nacc, input int shift);
      cfg_mode = mode; cfg_num_accum = CW'(nacc); cfg_shift = 6'(shift);
   endtask

   initial begin
      logic [N*W-1:0] a70, b70, a_max, gap_a, gap_b;
      int n0, edges, nacc;

      rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0;
      set_cfg(1'b0, 1, 0);
      a70 = pack4(1, 2, 3, 4);
      b70 = pack4(5, 6, 7, 8);
      step(3);
      chk("reset_out_valid", out_valid, 0);
      chk("reset_out_data", out_data, 0);
      chk("reset_out_accum", out_accum, 0);
      chk("reset_out_sat", out_sat, 0);
      chk("reset_busy", busy, 0);
      rst = 1'b0;
      step(1);

      // Single beat window, measured latency.
      n0 = out_log.size();
      in_a = a70; in_b = b70; in_valid = 1'b1;
      @(posedge clk);
      edges = 1;
      #1 in_valid = 1'b0;
      while (!out_valid && edges < 30) begin
         @(posedge clk);
         edges++;
         #1;
      end
      chk("latency_edges", edges, 5);
      chk("mode0_accum_live", out_accum, 70);
      wait_results(n0, 1);
      chk("mode0_data", out_log[n0].data, 70);

      wait_idle();
      set_cfg(1'b1, 1, 0);
      n0 = out_log.size();
      send(pack4(10, 0, -3, 7), pack4(4, 0, 5, 7));
      wait_results(n0, 1);
      chk("mode1_data", out_log[n0].data, 100);

      wait_idle();
      set_cfg(1'b0, 3, 0);
      n0 = out_log.size();
      repeat (3) send(a70, b70);
      wait_idle();
      chk("win3_count", out_log.size() - n0, 1);
      chk("win3_data", out_log[n0].data, 210);

      n0 = out_log.size();
      repeat (3) begin
         send(a70, b70);
         step(2);
      end
      wait_idle();
      chk("win3_gap_count", out_log.size() - n0, 1);
      chk("win3_gap_data", out_log[n0].data, 210);

      // Backpressure: two single-beat windows held behind out_ready=0.
      set_cfg(1'b0, 1, 0);
      ready_mode = 0;
      step(2);
      n0 = out_log.size();
      gap_a = pack4(10, 0, 0, 0);
      gap_b = pack4(10, 0, 0, 0);
      send(a70, b70);
      send(gap_a, gap_b);
      step(8);
      chk("stall_in_ready", in_ready, 0);
      chk("stall_out_valid", out_valid, 1);
      chk("stall_data_a", out_data, 70);
      step(3);
      chk("stall_data_b", out_data, 70);
      ready_mode = 1;
      wait_results(n0, 2);
      chk("release_first", out_log[n0].data, 70);
      chk("release_second", out_log[n0+1].data, 100);

      wait_idle();
      a_max = pack4(32767, 32767, 32767, 32767);
      n0 = out_log.size();
      send(a_max, a_max);
      wait_results(n0, 1);
      chk("max_accum", out_log[n0].accum, 48'h0000FFFC0004);
`ifdef CNN_LAYER_ACCEL_MACC_CHAIN_SAT_EN
      chk("max_data", out_log[n0].data, 32767);
      chk("max_sat", out_log[n0].sat, 1);
`else
      chk("max_data", out_log[n0].data, 4);
      chk("max_sat", out_log[n0].sat, 0);
`endif

      // Reset mid-window discards the partial sum.
      wait_idle();
      set_cfg(1'b0, 3, 0);
      n0 = out_log.size();
      send(a70, b70);
      send(a70, b70);
      rst = 1'b1;
      step(1);
      rst = 1'b0;
      chk("busy_after_reset", busy, 0);
      repeat (3) send(a70, b70);
      wait_idle();
      chk("reset_win_count", out_log.size() - n0, 1);
      chk("reset_win_data", out_log[n0].data, 210);

      // Randomized windows with random backpressure.
      ready_mode = 2;
      for (int w = 0; w < 30; w++) begin
         wait_idle();
         set_cfg(1'($urandom_range(0, 1)), $urandom_range(0, 4), $urandom_range(0, 12));
         nacc = (cfg_num_accum == 0) ? 1 : int'(cfg_num_accum);
         for (int b = 0; b < nacc; b++) begin
            step($urandom_range(0, 2));
            send({$urandom(), $urandom()}, {$urandom(), $urandom()});
         end
      end
      ready_mode = 1;
      wait_idle();
      chk("queue_drained", exp_q.size(), 0);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule

// File: doc/cnn_layer_accel_macc_chain.md
Name: cnn_layer_accel_macc_chain

Overview:
- Parametrised multi-lane multiply-accumulate engine; successor to the single-DSP macc cell in the CNN layer accelerator.
- Each beat: C_NUM_LANES operand pairs → per-lane product, or squared difference in mode 1 → registered adder tree → windowed accumulator over cfg_num_accum beats.
- Emits one scaled, width-reduced result per window on a valid/ready output; sits between the window buffer and the output/pooling stage.

Parameters:
- C_NUM_LANES, 4, operand pairs per beat (≥1).
- C_DSP_INPUT_WIDTH, 16, signed operand width W.
- C_INPUT_DELAY, 1, input register stages D (≥1).
- C_ACCUM_WIDTH, 48, accumulator width A (≥2W+2+CLOG2(C_NUM_LANES)).
- C_OUTPUT_WIDTH, 16, signed result width.
- C_CNT_WIDTH, 16, width of the window-length counter.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- cfg_mode  in  1  0 = a*b; 1 = (a-b)^2.
- cfg_num_accum  in  C_CNT_WIDTH  beats per window; 0 treated as 1.
- cfg_shift  in  6  arithmetic right shift applied to result.
- in_valid  in  1  beat valid.
- in_ready  out  1  beat accepted when in_valid&&in_ready.
- in_a  in  C_NUM_LANES*W  packed signed lane operands, lane0 = LSBs.
- in_b  in  C_NUM_LANES*W  packed signed lane operands.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accept.
- out_data  out  C_OUTPUT_WIDTH  signed scaled result.
- out_accum  out  A  raw unshifted window sum.
- out_sat  out  1  saturation occurred on this result.
- busy  out  1  any beat in flight or partial window held.

Behaviour:
- Reset: out_valid=0, out_data=0, out_accum=0, out_sat=0, busy=0, all stage valids=0, beat counter=0, accumulator=0. Reset mid-window discards the partial sum and in-flight beats.
- Pipeline: D input delay stages → product stage → T=CLOG2(C_NUM_LANES) registered adder-tree levels (T=0 for 1 lane) → accumulator/output stage.
- Latency: L = D+T+2 edges from acceptance of a window's final beat to out_valid. Defaults: L=5.
- Stall rule: ce = !(out_valid && !out_ready). in_ready = ce. When ce=0 every stage, valid bit and counter holds. No beat is ever dropped or duplicated.
- Mode 0: product = a*b, 2W bits signed.
- Mode 1: diff = a-b on W+1 bits, then square. Product is sign-extended to 2W+2 bits.
- Tree and accumulator sign-extend to A bits. Accumulation wraps modulo 2^A, two's complement.
- Window handling, on a valid beat at the accumulator stage:
  - counter==0: acc ← sum.
  - otherwise: acc ← acc+sum.
  - if counter==max(cfg_num_accum,1)-1: out_accum ← acc_next; out_data ← f(acc_next>>>cfg_shift); out_valid ← 1; counter ← 0.
  - otherwise: counter increments.
- out_valid clears on out_valid&&out_ready unless a new result loads in the same cycle. Back-to-back results are allowed when out_ready=1.
- cfg_* are quasi-static: they change only while busy=0. Results for changes while busy=1 are undefined and not checked.
- busy = any stage valid || counter≠0 || out_valid.

Optional Feature:
- Macro CNN_LAYER_ACCEL_MACC_CHAIN_SAT_EN.
- Defined: f() saturates the shifted value to the signed range [-2^(O-1), 2^(O-1)-1], where O = C_OUTPUT_WIDTH. out_sat=1 with that result when clamping occurred.
- Undefined: f() keeps the low C_OUTPUT_WIDTH bits (wrap). out_sat tied 0.
- out_accum is unaffected either way.

Test Plan:
- Mode 0, num_accum=1, shift=0, a={1,2,3,4}, b={5,6,7,8} → out_data=70, out_accum=70, out_valid exactly 5 edges after acceptance.
- Mode 1, a={10,0,-3,7}, b={4,0,5,7} → 36+0+64+0 = out_data 100.
- num_accum=3, three consecutive beats of the first-case operands → single out_valid pulse, out_data=210. Repeat with 2-cycle in_valid gaps → same 210.
- Backpressure:
  - Setup: out_ready=0, two num_accum=1 windows (70, then 100).
  - While stalled: in_ready falls after the first result loads; out_data holds 70 while stalled.
  - On release: 70 then 100 in order, with no loss.
- All lanes a=b=32767, num_accum=1, shift=0, mode 0:
  - With SAT_EN: out_data=32767, out_sat=1.
  - Without SAT_EN: out_data=0x0004, out_sat=0.
  - Either build: out_accum=0xFFFC0004.
- num_accum=3: two beats of 70, rst pulse for 1 cycle, then three beats of 70 → out_data=210 (not 350), busy=0 right after reset.
